// File: rtl/alu_issue_ctrl.sv
// Single-issue ALU sequencer: decodes an RV32I ALU/branch op, drives an external ALU,
// captures its result/flags and holds them until the consumer accepts.
module alu_issue_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_opcode,
  input  logic [2:0]  in_funct3,
  input  logic        in_funct7b5,
  input  logic [31:0] in_rs1_val,
  input  logic [31:0] in_rs2_val,
  input  logic [31:0] in_imm,
  input  logic [31:0] in_pc,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_ctrl,
  input  logic [31:0] alu_y,
  input  logic        alu_zero,
  input  logic        alu_neg,
  input  logic        alu_carry,
  input  logic        alu_over,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_branch_taken,
  output logic [31:0] out_branch_target,
  output logic        out_illegal
);

  localparam logic [2:0] ALU_NONE = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b011;
  localparam logic [2:0] ALU_OR   = 3'b100;
  localparam logic [2:0] ALU_SLT  = 3'b111;

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;

  typedef struct packed {
    logic [2:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic        br;
    logic        ill;
  } dec_t;

  state_t      state, state_nxt;
  dec_t        dec;
  logic        br_q, ill_q, taken;
  logic [2:0]  br_f3_q;
  logic [31:0] tgt_q;
  logic        xfer;
  logic        unused_carry;

  // Carry is part of the ALU interface but no supported op needs it.
  assign unused_carry = alu_carry;
  assign xfer = in_valid & in_ready;

  always_comb begin
    dec = '{ctrl: ALU_NONE, a: 32'd0, b: 32'd0, br: 1'b0, ill: 1'b1};
    unique case (in_opcode)
      7'b0110011, 7'b0010011: begin
        unique case (in_funct3)
          3'b000: begin
            dec.ill  = 1'b0;
            dec.ctrl = (in_opcode[5] && in_funct7b5) ? ALU_SUB : ALU_ADD;
          end
          3'b010: begin dec.ill = 1'b0; dec.ctrl = ALU_SLT; end
          3'b110: begin dec.ill = 1'b0; dec.ctrl = ALU_OR;  end
          default: ;
        endcase
        if (!dec.ill) begin
          dec.a = in_rs1_val;
          dec.b = in_opcode[5] ? in_rs2_val : in_imm;
        end
      end
      7'b1100011: begin
        if (in_funct3 inside {3'b000, 3'b001, 3'b100, 3'b101}) begin
          dec.ill  = 1'b0;
          dec.br   = 1'b1;
          dec.ctrl = ALU_SUB;
          dec.a    = in_rs1_val;
          dec.b    = in_rs2_val;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    unique case (br_f3_q)
      3'b000:  taken = alu_zero;
      3'b001:  taken = ~alu_zero;
      3'b100:  taken = alu_neg ^ alu_over;
      3'b101:  taken = ~(alu_neg ^ alu_over);
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (xfer) state_nxt = EXEC;
      EXEC:    state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // in_ready drops with rst_n itself, not only once the state register has cleared.
  always_comb begin
    in_ready  = (state == IDLE) && rst_n;
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a             <= '0;
      alu_b             <= '0;
      alu_ctrl          <= ALU_NONE;
      br_q              <= 1'b0;
      ill_q             <= 1'b0;
      br_f3_q           <= '0;
      tgt_q             <= '0;
      out_result        <= '0;
      out_branch_taken  <= 1'b0;
      out_branch_target <= '0;
      out_illegal       <= 1'b0;
    end else begin
      if (xfer) begin
        alu_a    <= dec.a;
        alu_b    <= dec.b;
        alu_ctrl <= dec.ctrl;
        br_q     <= dec.br;
        ill_q    <= dec.ill;
        br_f3_q  <= dec.br ? in_funct3 : 3'b000;
        tgt_q    <= dec.br ? in_pc + in_imm : 32'd0;
      end
      if (state == EXEC) begin
        out_result        <= (br_q || ill_q) ? 32'd0 : alu_y;
        out_branch_taken  <= br_q & taken;
        out_branch_target <= tgt_q;
        out_illegal       <= ill_q;
      end
    end
  end

endmodule
